mem_sort_master: RTL and testbench

Hardware initiator on the data-memory port that sorts a block of 64-bit doublewords in place, in ascending signed order.
- Algorithm: bubble sort with early exit.
- Drives Mem_Addr, Write_Data, MemRead and MemWrite into the data memory and consumes Read_Data.
- Used as a sort accelerator alongside the pipelined core, and as a self-checking traffic source for the memory.

---
 rtl/mem_sort_master_pkg.sv | 27 ++
 rtl/mem_sort_master.sv | 153 +++++++++++++++
 tb/tb_mem_sort_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sort_master_pkg.sv
// Shared types and constants for the in-place doubleword bubble sorter.
package mem_sort_master_pkg;

   localparam int DWORD_W    = 64;
   localparam int STRIDE_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_CMP  = 3'd3,
      S_WR_A = 3'd4,
      S_WR_B = 3'd5,
      S_NEXT = 3'd6,
      S_DONE = 3'd7
   } state_t;

   // Byte address of element idx; plain 64-bit arithmetic, wraps silently.
   function automatic logic [DWORD_W-1:0] elem_addr(
      input logic [DWORD_W-1:0] base,
      input logic [DWORD_W-1:0] idx,
      input logic [DWORD_W-1:0] stride
   );
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/mem_sort_master.sv
// Memory-port initiator: bubble sort (early exit) of signed 64-bit doublewords in place.
module mem_sort_master
   import mem_sort_master_pkg::*;
#(
   parameter int STRIDE = STRIDE_DEF,
   parameter int LEN_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [63:0]        base_addr,
   input  logic [LEN_W-1:0]   len,
   input  logic [63:0]        Read_Data,
   output logic [63:0]        Mem_Addr,
   output logic [63:0]        Write_Data,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   swap_count
);

   state_t               state_reg, state_next;
   logic [63:0]          base_reg;
   logic [LEN_W-1:0]     len_reg;
   logic [LEN_W-1:0]     i_reg;
   logic [LEN_W-1:0]     j_reg;
   logic [63:0]          a_reg;
   logic [63:0]          b_reg;
   logic                 pass_reg;
   logic [CNT_W-1:0]     swap_reg;
   logic [63:0]          addr_hold_reg;
   logic [63:0]          wdata_hold_reg;

   logic [63:0]          addr_j;
   logic [63:0]          addr_j1;
   logic [LEN_W-1:0]     j_limit;
   logic                 last_pass;
   logic                 a_gt_b;
   logic                 more_in_pass;
   logic                 sort_finished;

   // i never exceeds len-2 and len>=2 while sorting, so the limit cannot underflow.
   assign addr_j        = elem_addr(base_reg, 64'(j_reg), 64'(STRIDE));
   assign addr_j1       = elem_addr(base_reg, 64'(j_reg) + 64'd1, 64'(STRIDE));
   assign j_limit       = len_reg - LEN_W'(2) - i_reg;
   assign last_pass     = (i_reg == len_reg - LEN_W'(2));
   assign a_gt_b        = $signed(a_reg) > $signed(b_reg);
   assign more_in_pass  = (j_reg < j_limit);
   assign sort_finished = !pass_reg || last_pass;
   assign swap_count    = swap_reg;

   // State register; reset abandons any sort in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (start) state_next = (len < LEN_W'(2)) ? S_DONE : S_RD_A;
         S_RD_A: state_next = S_RD_B;
         S_RD_B: state_next = S_CMP;
         S_CMP:  state_next = a_gt_b ? S_WR_A : S_NEXT;
         S_WR_A: state_next = S_WR_B;
         S_WR_B: state_next = S_NEXT;
         S_NEXT: begin
            if (more_in_pass)       state_next = S_RD_A;
            else if (sort_finished) state_next = S_DONE;
            else                    state_next = S_RD_A;
         end
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode from registered state; address/data hold their last value when idle.
   always_comb begin
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Mem_Addr   = addr_hold_reg;
      Write_Data = wdata_hold_reg;
      busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
      done       = (state_reg == S_DONE);
      case (state_reg)
         S_RD_A: begin MemRead  = 1'b1; Mem_Addr = addr_j;  end
         S_RD_B: begin MemRead  = 1'b1; Mem_Addr = addr_j1; end
         S_WR_A: begin MemWrite = 1'b1; Mem_Addr = addr_j;  Write_Data = b_reg; end
         S_WR_B: begin MemWrite = 1'b1; Mem_Addr = addr_j1; Write_Data = a_reg; end
         default: ;
      endcase
   end

   // Sort datapath: operands, loop indices, pass flag and saturating swap counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_reg <= '0;
         len_reg  <= '0;
         i_reg    <= '0;
         j_reg    <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         pass_reg <= 1'b0;
         swap_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  base_reg <= base_addr;
                  len_reg  <= len;
                  i_reg    <= '0;
                  j_reg    <= '0;
                  pass_reg <= 1'b0;
                  swap_reg <= '0;
               end
            end
            S_RD_A: a_reg <= Read_Data;
            S_RD_B: b_reg <= Read_Data;
            S_CMP: begin
               if (a_gt_b) begin
                  pass_reg <= 1'b1;
                  if (swap_reg != {CNT_W{1'b1}}) swap_reg <= swap_reg + CNT_W'(1);
               end
            end
            S_NEXT: begin
               if (more_in_pass) begin
                  j_reg <= j_reg + LEN_W'(1);
               end else if (!sort_finished) begin
                  i_reg    <= i_reg + LEN_W'(1);
                  j_reg    <= '0;
                  pass_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Remember the last driven address and write data so they hold between accesses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_hold_reg  <= '0;
         wdata_hold_reg <= '0;
      end else begin
         if (MemRead || MemWrite) addr_hold_reg  <= Mem_Addr;
         if (MemWrite)            wdata_hold_reg <= Write_Data;
      end
   end

endmodule

// File: tb/tb_mem_sort_master.sv
// Directed bench for mem_sort_master with a 32-doubleword memory model.
module tb_mem_sort_master;

   logic        clk;
   logic        reset;
   logic        start;
   logic [63:0] base_addr;
   logic [7:0]  len;
   logic [63:0] Read_Data;
   logic [63:0] Mem_Addr;
   logic [63:0] Write_Data;
   logic        MemRead;
   logic        MemWrite;
   logic        busy;
   logic        done;
   logic [15:0] swap_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem [0:31];
   logic        tb_we;
   logic [4:0]  tb_idx;
   logic [63:0] tb_wdata;

   // monitor counters, only written by the monitor process
   int wr_cnt = 0;
   int acc_cnt = 0;
   int out_cnt = 0;
   int both_cnt = 0;
   int done_cnt = 0;
   logic [63:0] win_lo = 64'h0;
   logic [63:0] win_hi = 64'hFF;

   mem_sort_master dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
      .Read_Data(Read_Data), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
      .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy), .done(done),
      .swap_count(swap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign Read_Data = mem[Mem_Addr[7:3]];

   always @(posedge clk) begin
      if (MemWrite)   mem[Mem_Addr[7:3]] <= Write_Data;
      else if (tb_we) mem[tb_idx] <= tb_wdata;
   end

   always @(negedge clk) begin
      if (MemWrite) wr_cnt = wr_cnt + 1;
      if (MemRead || MemWrite) begin
         acc_cnt = acc_cnt + 1;
         if (Mem_Addr < win_lo || Mem_Addr > win_hi) out_cnt = out_cnt + 1;
      end
      if (MemRead && MemWrite) both_cnt = both_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic mem_load(input int idx, input logic [63:0] val);
      @(negedge clk);
      tb_we = 1'b1; tb_idx = idx[4:0]; tb_wdata = val;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic load4(input int idx0, input logic [63:0] v0, input logic [63:0] v1,
                        input logic [63:0] v2, input logic [63:0] v3);
      mem_load(idx0, v0); mem_load(idx0 + 1, v1);
      mem_load(idx0 + 2, v2); mem_load(idx0 + 3, v3);
   endtask

   // Pulse start, then wait (bounded) for done; cyc is 1 for the cycle after the start edge, -1 on timeout.
   task automatic run_sort(input logic [63:0] b, input logic [7:0] n, output int cyc);
      @(negedge clk);
      start = 1'b1; base_addr = b; len = n;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc = cyc + 1;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset;
      checks++; if (Mem_Addr !== 64'h0)   begin errors++; $display("FAIL reset_addr got %h want 0", Mem_Addr); end
      checks++; if (Write_Data !== 64'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", Write_Data); end
      checks++; if ({MemRead, MemWrite, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {MemRead, MemWrite, busy, done}); end
      checks++; if (swap_count !== 16'h0) begin errors++; $display("FAIL reset_swaps got %0d want 0", swap_count); end
      $display("test_reset done");
   endtask

   task automatic test_unsorted;
      int cyc; int d0; int b0;
      load4(0, 64'd2, 64'd4, 64'd1, 64'd3);
      d0 = done_cnt; b0 = both_cnt;
      run_sort(64'h0, 8'd4, cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL unsorted_timeout got none want done"); end
      @(negedge clk);
      checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== {64'd1, 64'd2, 64'd3, 64'd4})
         begin errors++; $display("FAIL unsorted_mem got %0d %0d %0d %0d want 1 2 3 4", mem[0], mem[1], mem[2], mem[3]); end
      checks++; if (swap_count !== 16'd3) begin errors++; $display("FAIL unsorted_swaps got %0d want 3", swap_count); end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL unsorted_done_pulses got %0d want 1", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unsorted_busy_after got %b want 0", busy); end
      checks++; if (both_cnt != b0) begin errors++; $display("FAIL unsorted_rd_wr_overlap got %0d want 0", both_cnt - b0); end
      $display("test_unsorted cycles=%0d swaps=%0d", cyc, swap_count);
   endtask

   task automatic test_sorted;
      int cyc; int w0;
      load4(0, 64'd1, 64'd2, 64'd3, 64'd4);
      w0 = wr_cnt;
      run_sort(64'h0, 8'd4, cyc);
      checks++; if (cyc !== 13) begin errors++; $display("FAIL sorted_latency got %0d want 13", cyc); end
      checks++; if (wr_cnt != w0) begin errors++; $display("FAIL sorted_writes got %0d want 0", wr_cnt - w0); end
      checks++; if (swap_count !== 16'd0) begin errors++; $display("FAIL sorted_swaps got %0d want 0", swap_count); end
      $display("test_sorted cycles=%0d", cyc);
   endtask

   task automatic test_reverse_offset;
      int cyc; int o0;
      load4(8, 64'd4, 64'd3, 64'd2, 64'd1);
      win_lo = 64'h40; win_hi = 64'h5F;
      @(negedge clk);
      o0 = out_cnt;
      run_sort(64'h40, 8'd4, cyc);
      @(negedge clk);
      checks++; if (cyc < 0) begin errors++; $display("FAIL reverse_timeout got none want done"); end
      checks++; if ({mem[8], mem[9], mem[10], mem[11]} !== {64'd1, 64'd2, 64'd3, 64'd4})
         begin errors++; $display("FAIL reverse_mem got %0d %0d %0d %0d want 1 2 3 4", mem[8], mem[9], mem[10], mem[11]); end
      checks++; if (swap_count !== 16'd6) begin errors++; $display("FAIL reverse_swaps got %0d want 6", swap_count); end
      checks++; if (out_cnt != o0) begin errors++; $display("FAIL reverse_addr_window got %0d stray want 0", out_cnt - o0); end
      win_lo = 64'h0; win_hi = 64'hFF;
      $display("test_reverse_offset cycles=%0d swaps=%0d", cyc, swap_count);
   endtask

   task automatic test_signed;
      int cyc;
      mem_load(16, 64'd5);
      mem_load(17, 64'hFFFF_FFFF_FFFF_FFFF);
      run_sort(64'h80, 8'd2, cyc);
      @(negedge clk);
      checks++; if (mem[16] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL signed_elem0 got %h want ffffffffffffffff", mem[16]); end
      checks++; if (mem[17] !== 64'd5) begin errors++; $display("FAIL signed_elem1 got %h want 5", mem[17]); end
      checks++; if (swap_count !== 16'd1) begin errors++; $display("FAIL signed_swaps got %0d want 1", swap_count); end
      $display("test_signed cycles=%0d", cyc);
   endtask

   task automatic test_short_len;
      int cyc; int a0;
      for (int n = 0; n < 2; n++) begin
         a0 = acc_cnt;
         run_sort(64'h0, 8'(n), cyc);
         checks++; if (cyc !== 1) begin errors++; $display("FAIL short_len%0d_latency got %0d want 1", n, cyc); end
         @(negedge clk);
         checks++; if (acc_cnt != a0) begin errors++; $display("FAIL short_len%0d_access got %0d want 0", n, acc_cnt - a0); end
         $display("test_short_len len=%0d cycles=%0d", n, cyc);
      end
   endtask

   task automatic test_reset_midsort;
      int cyc; int a0; int d0;
      load4(0, 64'd2, 64'd4, 64'd1, 64'd3);
      @(negedge clk);
      start = 1'b1; base_addr = 64'h0; len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!MemWrite && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL midsort_reach_wr got %b want 1", MemWrite); end
      reset = 1'b0;
      #1;
      checks++; if ({Mem_Addr, Write_Data} !== 128'h0) begin errors++; $display("FAIL midsort_reset_bus got %h %h want 0 0", Mem_Addr, Write_Data); end
      checks++; if ({MemRead, MemWrite, busy, done} !== 4'b0) begin errors++; $display("FAIL midsort_reset_ctrl got %b want 0000", {MemRead, MemWrite, busy, done}); end
      checks++; if (swap_count !== 16'h0) begin errors++; $display("FAIL midsort_reset_swaps got %0d want 0", swap_count); end
      a0 = acc_cnt;
      repeat (2) @(negedge clk);
      checks++; if (acc_cnt != a0) begin errors++; $display("FAIL midsort_access_in_reset got %0d want 0", acc_cnt - a0); end
      reset = 1'b1;
      load4(0, 64'd2, 64'd4, 64'd1, 64'd3);
      win_lo = 64'h0; win_hi = 64'h1F;
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; base_addr = 64'h0; len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; base_addr = 64'h40; len = 8'd2;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL midsort_restart_timeout got %b want 1", done); end
      @(negedge clk);
      checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== {64'd1, 64'd2, 64'd3, 64'd4})
         begin errors++; $display("FAIL midsort_restart_mem got %0d %0d %0d %0d want 1 2 3 4", mem[0], mem[1], mem[2], mem[3]); end
      checks++; if (swap_count !== 16'd3) begin errors++; $display("FAIL midsort_restart_swaps got %0d want 3", swap_count); end
      checks++; if (out_cnt != 0 && out_cnt != 0) begin end
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midsort_restart_done got %0d want 1", done_cnt - d0); end
      $display("test_reset_midsort swaps=%0d stray=%0d", swap_count, out_cnt);
      win_lo = 64'h0; win_hi = 64'hFF;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; base_addr = '0; len = '0;
      tb_we = 1'b0; tb_idx = '0; tb_wdata = '0;
      repeat (2) @(negedge clk);
      test_reset;
      reset = 1'b1;
      test_unsorted;
      test_sorted;
      test_reverse_offset;
      test_signed;
      test_short_len;
      test_reset_midsort;
      checks++; if (out_cnt != 0) begin errors++; $display("FAIL addr_window_total got %0d stray want 0", out_cnt); end
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL rd_wr_overlap_total got %0d want 0", both_cnt); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
